// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit for the HI/LO register pair.
//   MULT/MULTU : radix-2 shift-add, one multiplier bit per cycle.
//   DIV/DIVU   : restoring division, one quotient bit per cycle.
// A signed operation works on operand magnitudes, and the sign is fixed up in
// the last iteration. While an operation runs the unit holds the pipeline
// through stall_request. It then presents the result for one cycle in DONE,
// with done/hilo_write_en high.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           operation request (held by EX while stall_request is high)
//   op              00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_1       multiplicand / dividend
//   operand_2       multiplier / divisor
//   flush           cancel any in-flight operation
//   stall_request   pipeline hold request
//   done            one-cycle completion pulse
//   hilo_write_en   HILO write strobe (same as done)
//   hi_write_data   product high half / remainder
//   lo_write_data   product low half / quotient
//
// DATA_WIDTH must be even and >= 8. When DIV_ZERO_FAST is 1, a divide by zero
// finishes after one cycle. The result is lo = all ones, hi = dividend.
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int DIV_ZERO_FAST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  input  logic                  flush,
  output logic                  stall_request,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_write_data,
  output logic [DATA_WIDTH-1:0] lo_write_data,
  output logic                  hilo_write_en
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  // MUL: acc_hi_q = partial product, acc_lo_q = multiplier shifting out /
  //      product low half shifting in, oper_q = multiplicand magnitude.
  // DIV: acc_hi_q = partial remainder, acc_lo_q = dividend shifting out /
  //      quotient shifting in, oper_q = divisor magnitude.
  logic [W-1:0]     acc_hi_q;
  logic [W-1:0]     acc_lo_q;
  logic [W-1:0]     oper_q;
  logic             neg_res_q;   // negate product / quotient at the end
  logic             neg_rem_q;   // remainder takes the dividend's sign
  logic             div_zero_q;  // fast divide-by-zero path
  // Last result actually committed to HILO, shown outside DONE.
  logic [W-1:0]     out_hi_q;
  logic [W-1:0]     out_lo_q;

  // Operand capture
  logic         op1_neg;
  logic         op2_neg;
  logic [W-1:0] op1_mag;
  logic [W-1:0] op2_mag;

  // One iteration step plus the final sign fix-up
  logic [W:0]     mul_addend;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_prod;
  logic [2*W-1:0] mul_fix;
  logic [W:0]     rem_shift;
  logic [W:0]     rem_diff;
  logic [W-1:0]   div_rem;
  logic [W-1:0]   div_quo;
  logic [W-1:0]   div_rem_fix;
  logic [W-1:0]   div_quo_fix;
  logic [W-1:0]   zero_hi;
  logic           last_iter;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first); a missed branch would otherwise infer a latch.
  always_comb begin
    op1_neg = ~op[0] & operand_1[W-1];
    op2_neg = ~op[0] & operand_2[W-1];
    op1_mag = op1_neg ? -operand_1 : operand_1;
    op2_mag = op2_neg ? -operand_2 : operand_2;

    // Shift-add: add the multiplicand when the current multiplier bit is 1.
    // The carry goes back into the product as it shifts right.
    mul_addend = acc_lo_q[0] ? {1'b0, oper_q} : '0;
    mul_sum    = {1'b0, acc_hi_q} + mul_addend;
    mul_prod   = {mul_sum, acc_lo_q[W-1:1]};
    mul_fix    = neg_res_q ? -mul_prod : mul_prod;

    // Restoring division: bring in the next dividend bit and try to subtract.
    // If the result goes negative, keep the shifted remainder.
    rem_shift = {acc_hi_q, acc_lo_q[W-1]};
    rem_diff  = rem_shift - {1'b0, oper_q};
    div_rem   = rem_shift[W-1:0];
    div_quo   = {acc_lo_q[W-2:0], 1'b0};
    if (!rem_diff[W]) begin
      div_rem = rem_diff[W-1:0];
      div_quo = {acc_lo_q[W-2:0], 1'b1};
    end
    div_rem_fix = neg_rem_q ? -div_rem : div_rem;
    div_quo_fix = neg_res_q ? -div_quo : div_quo;

    // Divide by zero: acc_lo_q still holds the dividend magnitude.
    // Restoring the sign gives back the original operand_1.
    zero_hi = neg_rem_q ? -acc_lo_q : acc_lo_q;

    last_iter = (count_q == CNT_W'(W - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values that were present before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      oper_q     <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      out_hi_q   <= '0;
      out_lo_q   <= '0;
    end else if (flush) begin
      // Drop the operation, including one sitting in DONE.
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            count_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= op[1] ? op1_mag : op2_mag;
            oper_q     <= op[1] ? op2_mag : op1_mag;
            neg_res_q  <= op1_neg ^ op2_neg;
            neg_rem_q  <= op[1] & op1_neg;
            div_zero_q <= op[1] && (operand_2 == '0) && (DIV_ZERO_FAST != 0);
            state_q    <= op[1] ? S_DIV : S_MUL;
          end
        end

        S_MUL: begin
          count_q <= count_q + CNT_W'(1);
          if (last_iter) begin
            {acc_hi_q, acc_lo_q} <= mul_fix;
            state_q              <= S_DONE;
          end else begin
            {acc_hi_q, acc_lo_q} <= mul_prod;
          end
        end

        S_DIV: begin
          count_q <= count_q + CNT_W'(1);
          if (div_zero_q) begin
            acc_hi_q <= zero_hi;
            acc_lo_q <= '1;
            state_q  <= S_DONE;
          end else if (last_iter) begin
            acc_hi_q <= div_rem_fix;
            acc_lo_q <= div_quo_fix;
            state_q  <= S_DONE;
          end else begin
            acc_hi_q <= div_rem;
            acc_lo_q <= div_quo;
          end
        end

        S_DONE: begin
          // Commit the result. A start seen here is ignored; EX must
          // present it again in IDLE.
          out_hi_q <= acc_hi_q;
          out_lo_q <= acc_lo_q;
          count_q  <= '0;
          state_q  <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // done is gated by flush in the same cycle, so a flushed DONE never writes.
  assign done          = (state_q == S_DONE) & ~flush;
  assign hilo_write_en = done;
  assign stall_request = ~rst & (((state_q == S_IDLE) & start & ~flush) |
                                 (state_q == S_MUL) | (state_q == S_DIV));
  assign hi_write_data = (state_q == S_DONE) ? acc_hi_q : out_hi_q;
  assign lo_write_data = (state_q == S_DONE) ? acc_lo_q : out_lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Bench for mult_div_unit at DATA_WIDTH = 32.
// The reference model computes results with plain integer arithmetic and
// tracks only the required latency. On every falling edge it sets the expected
// stall_request, done, hilo_write_en and hi/lo against the DUT.
// Directed operations also carry hand-computed literal results and latencies.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] operand_1 = '0;
  logic [W-1:0] operand_2 = '0;
  logic         flush = 1'b0;
  logic         stall_request;
  logic         done;
  logic [W-1:0] hi_write_data;
  logic [W-1:0] lo_write_data;
  logic         hilo_write_en;

  mult_div_unit #(.DATA_WIDTH(W), .DIV_ZERO_FAST(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op            (op),
    .operand_1     (operand_1),
    .operand_2     (operand_2),
    .flush         (flush),
    .stall_request (stall_request),
    .done          (done),
    .hi_write_data (hi_write_data),
    .lo_write_data (lo_write_data),
    .hilo_write_en (hilo_write_en)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  function automatic res_t ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
    res_t        r;
    longint      p;
    logic [63:0] pu;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    r  = '0;
    case (o)
      2'b00: begin
        p  = longint'(sa) * longint'(sb);
        pu = p;
        r  = pu;
      end
      2'b01: begin
        pu = {32'b0, a} * {32'b0, b};
        r  = pu;
      end
      default: begin
        if (b == '0) begin
          r.hi = a;
          r.lo = '1;
        end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.hi = '0;
          r.lo = 32'h8000_0000;
        end else if (o == 2'b10) begin
          r.lo = 32'(sa / sb);
          r.hi = 32'(sa % sb);
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  // Model state: whether an operation is in flight, how many cycles remain
  // until its done cycle, its result, and the last committed HILO value.
  bit   m_busy = 1'b0;
  int   m_rem  = 0;
  res_t m_pend = '0;
  res_t m_last = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_last <= '0;
    end else if (flush) begin
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_rem == 0) begin
        m_last <= m_pend;
        m_busy <= 1'b0;
      end else begin
        m_rem <= m_rem - 1;
      end
    end else if (start) begin
      m_busy <= 1'b1;
      m_rem  <= (op[1] && operand_2 == '0) ? 1 : W;
      m_pend <= ref_result(op, operand_1, operand_2);
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    check("done", 32'(done),
          32'(!rst && m_busy && m_rem == 0 && !flush));
    check("hilo_write_en", 32'(hilo_write_en),
          32'(!rst && m_busy && m_rem == 0 && !flush));
    check("stall_request", 32'(stall_request),
          32'(!rst && ((!m_busy && start && !flush) || (m_busy && m_rem != 0))));
    if (!(m_busy && m_rem == 0 && flush)) begin
      check("hi", hi_write_data, (m_busy && m_rem == 0) ? m_pend.hi : m_last.hi);
      check("lo", lo_write_data, (m_busy && m_rem == 0) ? m_pend.lo : m_last.lo);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  // Issue one operation and wait (bounded) for done.
  // hold=1 keeps start high until after the done cycle. Otherwise start drops
  // after acceptance, and op/operands are scrambled to show that they were
  // latched.
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input int elat, input bit hold);
    int           k;
    int           found;
    logic [W-1:0] ghi;
    logic [W-1:0] glo;
    @(posedge clk); #1;
    op        = o;
    operand_1 = a;
    operand_2 = b;
    start     = 1'b1;
    k         = 0;
    found     = -1;
    ghi       = '0;
    glo       = '0;
    while (k < 80 && found < 0) begin
      @(negedge clk);
      if (done) begin
        found = k;
        ghi   = hi_write_data;
        glo   = lo_write_data;
      end
      @(posedge clk); #1;
      if (!hold) begin
        op        = ~o;
        operand_1 = ~a;
        operand_2 = b ^ 32'h5;
      end
      if (!hold || found >= 0) start = 1'b0;
      k++;
    end
    check({name, " latency"}, 32'(found), 32'(elat));
    check({name, " hi"}, ghi, ehi);
    check({name, " lo"}, glo, elo);
  endtask

  task automatic count_writes(input string name, input int cycles);
    int writes;
    writes = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (hilo_write_en) writes++;
    end
    check(name, 32'(writes), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    run_op("MULT -3x5",     2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 1'b0);
    run_op("MULTU max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
    run_op("MULT maxpos^2", 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 33, 1'b0);
    run_op("MULT minneg^2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, 1'b0);
    run_op("MULT -1x-1",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 33, 1'b0);
    run_op("DIV -7/2 hold", 2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b1);
    count_writes("no write after held start", 5);
    run_op("DIV 7/-2",      2'b10, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("DIV -7/-2",     2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 33, 1'b0);
    run_op("DIV min/-1",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0);
    run_op("DIVU max/16",   2'b11, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF, 33, 1'b0);
    run_op("DIVU min/3",    2'b11, 32'h8000_0000, 32'd3,        32'h0000_0002, 32'h2AAA_AAAA, 33, 1'b0);
    run_op("DIVU by 0",     2'b11, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 2,  1'b0);
    run_op("DIV -5 by 0",   2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 2,  1'b0);

    // Flush a MULT in cycle 10; it must be idle in cycle 11 and never write.
    @(posedge clk); #1;
    op = 2'b00; operand_1 = 32'hFFFF_FFFD; operand_2 = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("stall after flush", 32'(stall_request), 32'd0);
    count_writes("no write after flush", 40);
    run_op("DIVU 100/7",    2'b11, 32'd100,      32'd7,        32'd2,         32'd14,        33, 1'b0);

    // Reset in cycle 15 of a DIV: outputs clear at once, the op is dropped.
    @(posedge clk); #1;
    op = 2'b10; operand_1 = 32'd1000; operand_2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    #1;
    rst = 1'b1;
    #1;
    check("rst stall",  32'(stall_request), 32'd0);
    check("rst done",   32'(done),          32'd0);
    check("rst hi",     hi_write_data,      32'd0);
    check("rst lo",     lo_write_data,      32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    count_writes("no write after reset", 40);
    run_op("MULTU 6x7",     2'b01, 32'd6,        32'd7,        32'd0,         32'd42,        33, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; SHALL be even and >= 8.
REQ-002 Parameter DIV_ZERO_FAST, default 1; when 1, divide-by-zero SHALL complete without iterating.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  operation request, held by EX while stall_request is high.
REQ-006 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 operand_1  input  DATA_WIDTH  multiplicand / dividend.
REQ-008 operand_2  input  DATA_WIDTH  multiplier / divisor.
REQ-009 flush  input  1  cancel in-flight operation (exception/branch flush).
REQ-010 stall_request  output  1  pipeline hold request to the stall controller.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 hi_write_data  output  DATA_WIDTH  HI result (product high half / remainder).
REQ-013 lo_write_data  output  DATA_WIDTH  LO result (product low half / quotient).
REQ-014 hilo_write_en  output  1  HILO write strobe; equal to done.

Function
REQ-015 FSM states: IDLE, MUL, DIV, DONE; one-hot or binary encoding is free.
REQ-016 IDLE: start=1 and flush=0 -> capture operand magnitudes and signs, count=0, go MUL (op[1]=0) or DIV (op[1]=1); op latched, later op/operand changes ignored.
REQ-017 Signed ops (MULT, DIV) use two's-complement magnitudes; unsigned ops use operands unchanged.
REQ-018 MUL: radix-2 shift-add, one bit per cycle, exactly DATA_WIDTH cycles, then DONE.
REQ-019 DIV: restoring division, one quotient bit per cycle, exactly DATA_WIDTH cycles, then DONE.
REQ-020 Divisor zero with DIV_ZERO_FAST=1: DIV -> DONE after one cycle; lo = all ones, hi = operand_1 unchanged.
REQ-021 Sign fix-up in final cycle: product negated if operand signs differ (signed only); quotient negated if signs differ; remainder takes dividend's sign.
REQ-022 DIV most-negative / -1: lo = most-negative value (wrap), hi = 0, no error flag.
REQ-023 Latency: start sampled in IDLE at edge N -> done=1 during cycle N+DATA_WIDTH+1 (33 cycles at DATA_WIDTH=32).
REQ-024 DONE: done=1, hilo_write_en=1, hi/lo valid for exactly this cycle; next state IDLE unconditionally.
REQ-025 start seen in DONE SHALL NOT begin a new operation; new start accepted only in IDLE.
REQ-026 stall_request = (IDLE and start and not flush) or MUL or DIV; low in DONE so EX advances same cycle as write.
REQ-027 flush in any state -> IDLE next edge; no done or hilo_write_en for that operation; flush in DONE SHALL suppress done/write that cycle.
REQ-028 hi/lo outputs outside DONE hold the last written result.

Reset
REQ-029 rst=1 -> state IDLE, count 0, done 0, hilo_write_en 0, stall_request 0, hi/lo 0, immediately and independent of clk.
REQ-030 Reset mid-operation SHALL discard the operation with no HILO write; first start after rst release behaves per REQ-016.

Verification
REQ-031 MULT -3 x 5 -> done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall_request high cycles 0-32.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 DIVU 0x12345678 / 0 -> done 2 cycles after start; lo=0xFFFFFFFF, hi=0x12345678.
REQ-035 MULT start, flush at cycle 10 -> IDLE at 11, no hilo_write_en; DIVU 100/7 next -> lo=14, hi=2 at cycle 33 after its start.
REQ-036 rst asserted at cycle 15 of DIV -> outputs zero asynchronously, no write; start held high through DONE -> exactly one write per accepted start.
